// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank and the bus selector:
// register widths, register index map and bus read-select codes.
package reg_bank_pkg;

    localparam int unsigned NW   = 8;
    localparam int unsigned WW   = 16;
    localparam int unsigned NREG = 10;

    // Bit positions inside write_en / inc_en / clr_en
    localparam int unsigned REG_PC = 0;
    localparam int unsigned REG_DR = 1;
    localparam int unsigned REG_R  = 2;
    localparam int unsigned REG_AC = 3;
    localparam int unsigned REG_TR = 4;
    localparam int unsigned REG_R1 = 5;
    localparam int unsigned REG_R2 = 6;
    localparam int unsigned REG_RI = 7;
    localparam int unsigned REG_RJ = 8;
    localparam int unsigned REG_RK = 9;

    // Bus selector read-select codes; numerically equal to the register index
    typedef enum logic [3:0] {
        SEL_PC   = 4'd0,
        SEL_DR   = 4'd1,
        SEL_R    = 4'd2,
        SEL_AC   = 4'd3,
        SEL_TR   = 4'd4,
        SEL_R1   = 4'd5,
        SEL_R2   = 4'd6,
        SEL_RI   = 4'd7,
        SEL_RJ   = 4'd8,
        SEL_RK   = 4'd9,
        SEL_NONE = 4'd15
    } bus_sel_e;

    // True for the registers that span the full bus width
    function automatic logic is_wide(input int unsigned idx);
        return (idx == REG_AC) || (idx == REG_TR);
    endfunction

endpackage

// File: rtl/reg_bank_ctr_reg.sv
// Single register with clear > load > increment > hold priority.
module ctr_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Register update: async clear on rst, then clr > ld > inc > hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end else if (inc) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/reg_bank.sv
// Processor register bank fed from the shared 16-bit bus. Each register
// is a ctr_reg; AC additionally accepts the ALU result on its load path.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned NW   = reg_bank_pkg::NW,
    parameter int unsigned WW   = reg_bank_pkg::WW,
    parameter int unsigned NREG = reg_bank_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WW-1:0]   bus_in,
    input  logic [NREG-1:0] write_en,
    input  logic [NREG-1:0] inc_en,
    input  logic [NREG-1:0] clr_en,
    input  logic            alu_we,
    input  logic [WW-1:0]   alu_in,
    output logic [NW-1:0]   pc,
    output logic [NW-1:0]   dr,
    output logic [NW-1:0]   r,
    output logic [NW-1:0]   r1,
    output logic [NW-1:0]   r2,
    output logic [NW-1:0]   ri,
    output logic [NW-1:0]   rj,
    output logic [NW-1:0]   rk,
    output logic [WW-1:0]   ac,
    output logic [WW-1:0]   tr,
    output logic            z,
    output logic            ri_eq_r1,
    output logic            rj_eq_r2
);

    logic            w_ac_ld;
    logic [WW-1:0]   w_ac_d;
    logic [NW-1:0]   w_bus_n;

    assign w_bus_n = bus_in[NW-1:0];

    // AC load path: a bus write outranks the ALU writeback; both outrank inc
    always_comb begin
        w_ac_ld = write_en[REG_AC] | alu_we;
        w_ac_d  = write_en[REG_AC] ? bus_in : alu_in;
    end

    ctr_reg #(.W(NW)) u_pc (.clk(clk), .rst(rst), .clr(clr_en[REG_PC]), .ld(write_en[REG_PC]),
                            .inc(inc_en[REG_PC]), .d(w_bus_n), .q(pc));
    ctr_reg #(.W(NW)) u_dr (.clk(clk), .rst(rst), .clr(clr_en[REG_DR]), .ld(write_en[REG_DR]),
                            .inc(inc_en[REG_DR]), .d(w_bus_n), .q(dr));
    ctr_reg #(.W(NW)) u_r  (.clk(clk), .rst(rst), .clr(clr_en[REG_R]),  .ld(write_en[REG_R]),
                            .inc(inc_en[REG_R]),  .d(w_bus_n), .q(r));
    ctr_reg #(.W(WW)) u_ac (.clk(clk), .rst(rst), .clr(clr_en[REG_AC]), .ld(w_ac_ld),
                            .inc(inc_en[REG_AC]), .d(w_ac_d),  .q(ac));
    ctr_reg #(.W(WW)) u_tr (.clk(clk), .rst(rst), .clr(clr_en[REG_TR]), .ld(write_en[REG_TR]),
                            .inc(inc_en[REG_TR]), .d(bus_in),  .q(tr));
    ctr_reg #(.W(NW)) u_r1 (.clk(clk), .rst(rst), .clr(clr_en[REG_R1]), .ld(write_en[REG_R1]),
                            .inc(inc_en[REG_R1]), .d(w_bus_n), .q(r1));
    ctr_reg #(.W(NW)) u_r2 (.clk(clk), .rst(rst), .clr(clr_en[REG_R2]), .ld(write_en[REG_R2]),
                            .inc(inc_en[REG_R2]), .d(w_bus_n), .q(r2));
    ctr_reg #(.W(NW)) u_ri (.clk(clk), .rst(rst), .clr(clr_en[REG_RI]), .ld(write_en[REG_RI]),
                            .inc(inc_en[REG_RI]), .d(w_bus_n), .q(ri));
    ctr_reg #(.W(NW)) u_rj (.clk(clk), .rst(rst), .clr(clr_en[REG_RJ]), .ld(write_en[REG_RJ]),
                            .inc(inc_en[REG_RJ]), .d(w_bus_n), .q(rj));
    ctr_reg #(.W(NW)) u_rk (.clk(clk), .rst(rst), .clr(clr_en[REG_RK]), .ld(write_en[REG_RK]),
                            .inc(inc_en[REG_RK]), .d(w_bus_n), .q(rk));

    // Status flags derived purely from register state
    always_comb begin
        z        = (ac == '0);
        ri_eq_r1 = (ri == r1);
        rj_eq_r2 = (rj == r2);
    end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a value-array model.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic [15:0] alu_in;
    logic [9:0]  write_en;
    logic [9:0]  inc_en;
    logic [9:0]  clr_en;
    logic        alu_we;
    logic [7:0]  pc, dr, r, r1, r2, ri, rj, rk;
    logic [15:0] ac, tr;
    logic        z, ri_eq_r1, rj_eq_r2;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // Model: plain array of register values, index = mask bit position
    int unsigned m [10];

    always #5 clk = ~clk;

    reg_bank #(.NW(8), .WW(16), .NREG(10)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .write_en(write_en),
        .inc_en(inc_en), .clr_en(clr_en), .alu_we(alu_we), .alu_in(alu_in),
        .pc(pc), .dr(dr), .r(r), .r1(r1), .r2(r2), .ri(ri), .rj(rj), .rk(rk),
        .ac(ac), .tr(tr), .z(z), .ri_eq_r1(ri_eq_r1), .rj_eq_r2(rj_eq_r2)
    );

    function automatic int unsigned modulus(input int idx);
        return (idx == 3 || idx == 4) ? 32'd65536 : 32'd256;
    endfunction

    // Model update: value chosen by priority, arithmetic done modulo 2^width
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 10; i++) begin
            if (rst)                    m[i] <= 0;
            else if (clr_en[i])         m[i] <= 0;
            else if (write_en[i])       m[i] <= int'(bus_in) % modulus(i);
            else if (i == 3 && alu_we)  m[i] <= int'(alu_in);
            else if (inc_en[i])         m[i] <= (m[i] + 1) % modulus(i);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (started) begin
            chk("pc", {24'd0, pc}, m[0]);
            chk("dr", {24'd0, dr}, m[1]);
            chk("r",  {24'd0, r},  m[2]);
            chk("ac", {16'd0, ac}, m[3]);
            chk("tr", {16'd0, tr}, m[4]);
            chk("r1", {24'd0, r1}, m[5]);
            chk("r2", {24'd0, r2}, m[6]);
            chk("ri", {24'd0, ri}, m[7]);
            chk("rj", {24'd0, rj}, m[8]);
            chk("rk", {24'd0, rk}, m[9]);
            chk("z",        {31'd0, z},        {31'd0, m[3] == 0});
            chk("ri_eq_r1", {31'd0, ri_eq_r1}, {31'd0, m[7] == m[5]});
            chk("rj_eq_r2", {31'd0, rj_eq_r2}, {31'd0, m[8] == m[6]});
        end
    end

    // Apply one cycle of controls; returns at the following falling edge
    task automatic drive(input logic [9:0] we, input logic [9:0] inc, input logic [9:0] clr,
                         input logic aw, input logic [15:0] bus, input logic [15:0] alu);
        write_en = we;
        inc_en   = inc;
        clr_en   = clr;
        alu_we   = aw;
        bus_in   = bus;
        alu_in   = alu;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc"}, {24'd0, pc}, 0);
        chk({tag, "_ri"}, {24'd0, ri}, 0);
        chk({tag, "_rk"}, {24'd0, rk}, 0);
        chk({tag, "_ac"}, {16'd0, ac}, 0);
        chk({tag, "_tr"}, {16'd0, tr}, 0);
        chk({tag, "_z"},  {31'd0, z}, 1);
        chk({tag, "_eq1"}, {31'd0, ri_eq_r1}, 1);
        chk({tag, "_eq2"}, {31'd0, rj_eq_r2}, 1);
    endtask

    initial begin
        rst = 1'b0; bus_in = '0; alu_in = '0;
        write_en = '0; inc_en = '0; clr_en = '0; alu_we = 1'b0;
        #1 rst = 1'b1;
        #20;
        @(negedge clk);
        started = 1'b1;
        chk_all_zero("por");
        #2 rst = 1'b0;
        @(negedge clk);

        // Async reset between edges; pending load discarded until rst drops
        drive(10'h3FF, '0, '0, 1'b0, 16'h1234, 16'h0);
        chk("ld_all_pc", {24'd0, pc}, 32'h34);
        chk("ld_all_ac", {16'd0, ac}, 32'h1234);
        write_en = 10'h3FF; bus_in = 16'hBEEF;
        #2 rst = 1'b1;
        #1 chk_all_zero("arst");
        @(negedge clk);
        chk_all_zero("arst_hold");
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_pc", {24'd0, pc}, 32'hEF);
        chk("post_rst_ac", {16'd0, ac}, 32'hBEEF);
        drive(10'h0, '0, 10'h3FF, 1'b0, 16'h0, 16'h0);

        // Broadcast load to RI/RJ/RK, then AC
        drive(10'h380, '0, '0, 1'b0, 16'hA55A, 16'h0);
        chk("bc_ri", {24'd0, ri}, 32'h5A);
        chk("bc_rj", {24'd0, rj}, 32'h5A);
        chk("bc_rk", {24'd0, rk}, 32'h5A);
        chk("bc_pc", {24'd0, pc}, 32'h00);
        drive(10'h008, '0, '0, 1'b0, 16'hA55A, 16'h0);
        chk("bc_ac", {16'd0, ac}, 32'hA55A);
        chk("bc_z",  {31'd0, z}, 0);

        // PC priority chain
        drive(10'h001, '0, '0, 1'b0, 16'h0010, 16'h0);
        chk("pri_ld", {24'd0, pc}, 32'h10);
        drive(10'h001, 10'h001, 10'h001, 1'b0, 16'h0077, 16'h0);
        chk("pri_clr", {24'd0, pc}, 32'h00);
        drive(10'h001, 10'h001, '0, 1'b0, 16'h4433, 16'h0);
        chk("pri_we", {24'd0, pc}, 32'h33);
        drive('0, 10'h001, '0, 1'b0, 16'h0, 16'h0);
        chk("pri_inc", {24'd0, pc}, 32'h34);

        // AC: bus write beats ALU writeback
        drive(10'h008, 10'h008, '0, 1'b1, 16'h0001, 16'h0002);
        chk("ac_we", {16'd0, ac}, 32'h0001);
        drive('0, 10'h008, '0, 1'b1, 16'h0005, 16'h0002);
        chk("ac_alu", {16'd0, ac}, 32'h0002);

        // Wraparound
        drive(10'h080, '0, '0, 1'b0, 16'h12FF, 16'h0);
        chk("wrap_ri_ld", {24'd0, ri}, 32'hFF);
        drive('0, 10'h080, '0, 1'b0, 16'h0, 16'h0);
        chk("wrap_ri", {24'd0, ri}, 32'h00);
        drive(10'h008, '0, '0, 1'b0, 16'hFFFF, 16'h0);
        chk("wrap_ac_ld", {16'd0, ac}, 32'hFFFF);
        drive('0, 10'h008, '0, 1'b0, 16'h0, 16'h0);
        chk("wrap_ac", {16'd0, ac}, 32'h0000);
        chk("wrap_z", {31'd0, z}, 1);

        // Loop compare: r1=3, ri counts up from 0
        drive(10'h020, '0, 10'h080, 1'b0, 16'h0003, 16'h0);
        chk("loop0", {31'd0, ri_eq_r1}, 0);
        drive('0, 10'h080, '0, 1'b0, 16'h0, 16'h0);
        chk("loop1", {31'd0, ri_eq_r1}, 0);
        drive('0, 10'h080, '0, 1'b0, 16'h0, 16'h0);
        chk("loop2", {31'd0, ri_eq_r1}, 0);
        drive('0, 10'h080, '0, 1'b0, 16'h0, 16'h0);
        chk("loop3", {31'd0, ri_eq_r1}, 1);
        drive('0, '0, '0, 1'b0, 16'h0, 16'h0);
        drive('0, '0, '0, 1'b0, 16'h0, 16'h0);
        chk("loop_idle", {31'd0, ri_eq_r1}, 1);

        // Randomized traffic, occasional short async reset pulse
        repeat (1500) begin
            logic [15:0] bus;
            bus = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            write_en = 10'($urandom) & 10'($urandom);
            inc_en   = 10'($urandom);
            clr_en   = 10'($urandom) & 10'($urandom) & 10'($urandom);
            alu_we   = 1'($urandom);
            bus_in   = bus;
            alu_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
